// File: rtl/arbiter_pkg.sv
// Shared definitions for the I/D cache to system-bus arbiter.
// Holds the FSM state encoding, tag width, READ/WRITE tag-bit values and
// the number of bus beats that make up one cache block.
package arbiter_pkg;

  localparam int TAGWIDTH        = 13;
  localparam int BEATS_PER_BLOCK = 8;

  // Value of tag bit TAGWIDTH-1 for each transaction direction.
  localparam logic TAG_READ  = 1'b1;
  localparam logic TAG_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    BUS_ADDR,
    BUS_WDATA,
    BUS_RDATA,
    CACHE_RESP
  } state_t;

endpackage

// File: rtl/mod_block_shifter.sv
// Block serializer/deserializer: holds one cache block and a 3-bit beat index.
// Ports: load/load_data (capture block, index 0), shift_out (advance after a
// sent beat), shift_in/beat_in (store beat at index, advance), beat_out,
// block, idx, last (index at final beat). Index wraps 7->0 naturally.
module mod_block_shifter
  import arbiter_pkg::*;
#(
  parameter int BLOCKBITS = 512,
  parameter int BUSWIDTH  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BLOCKBITS-1:0] load_data,
  input  logic                 shift_out,
  input  logic                 shift_in,
  input  logic [BUSWIDTH-1:0]  beat_in,
  output logic [BUSWIDTH-1:0]  beat_out,
  output logic [BLOCKBITS-1:0] block,
  output logic [2:0]           idx,
  output logic                 last
);

  logic [BLOCKBITS-1:0] blk;
  logic [2:0]           beat_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk      <= '0;
      beat_idx <= '0;
    end else if (load) begin
      blk      <= load_data;
      beat_idx <= '0;
    end else begin
      if (shift_in)
        blk[int'(beat_idx)*BUSWIDTH +: BUSWIDTH] <= beat_in;
      if (shift_in || shift_out)
        beat_idx <= beat_idx + 3'd1;
    end
  end

  assign beat_out = blk[int'(beat_idx)*BUSWIDTH +: BUSWIDTH];
  assign block    = blk;
  assign idx      = beat_idx;
  assign last     = (beat_idx == 3'(BEATS_PER_BLOCK - 1));

endmodule

// File: rtl/mod_cache_arbiter.sv
// Arbitrates I- and D-cache block requests onto a 64-bit system bus, one
// transaction at a time: address beat, then 8 write beats or 8 read beats,
// then a block response to the granted cache.
// Ports: i_*/d_* cache request/response channels, bus_* bus channels,
// clk, reset (async active-low).
// Build option ARB_DCACHE_PRIORITY_EN: d always wins ties (default: round-robin).
module mod_cache_arbiter
  import arbiter_pkg::*;
#(
  parameter int BLOCKBITS = 512,
  parameter int BUSWIDTH  = 64,
  parameter int TAGWIDTH  = arbiter_pkg::TAGWIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_reqcyc,
  output logic                 i_reqack,
  input  logic [63:0]          i_req,
  input  logic [TAGWIDTH-1:0]  i_reqtag,
  input  logic [BLOCKBITS-1:0] i_reqdata,
  output logic                 i_respcyc,
  input  logic                 i_respack,
  output logic [BLOCKBITS-1:0] i_resp,
  output logic [TAGWIDTH-1:0]  i_resptag,
  input  logic                 d_reqcyc,
  output logic                 d_reqack,
  input  logic [63:0]          d_req,
  input  logic [TAGWIDTH-1:0]  d_reqtag,
  input  logic [BLOCKBITS-1:0] d_reqdata,
  output logic                 d_respcyc,
  input  logic                 d_respack,
  output logic [BLOCKBITS-1:0] d_resp,
  output logic [TAGWIDTH-1:0]  d_resptag,
  output logic                 bus_reqcyc,
  input  logic                 bus_reqack,
  output logic [63:0]          bus_req,
  output logic [TAGWIDTH-1:0]  bus_reqtag,
  input  logic                 bus_respcyc,
  output logic                 bus_respack,
  input  logic [63:0]          bus_resp,
  input  logic [TAGWIDTH-1:0]  bus_resptag
);

  state_t              state;
  logic                gnt_d;      // granted requester is the D-cache
  logic                rr_d;       // next contested grant goes to d
  logic [63:0]         addr_q;
  logic [TAGWIDTH-1:0] tag_q;
  logic [TAGWIDTH-1:0] rd_bus_tag; // bus tag of read beat 0, kept for debug
  logic                pick_d;
  logic                load;
  logic                is_read;
  logic                in_resp;
  logic [BUSWIDTH-1:0] beat_out;
  logic [BLOCKBITS-1:0] block;
  logic [2:0]          idx;
  logic                last;

`ifdef ARB_DCACHE_PRIORITY_EN
  assign pick_d = d_reqcyc;
`else
  assign pick_d = d_reqcyc && (rr_d || !i_reqcyc);
`endif

  assign load    = (state == IDLE) && (i_reqcyc || d_reqcyc);
  assign is_read = (tag_q[TAGWIDTH-1] == TAG_READ);

  mod_block_shifter #(.BLOCKBITS(BLOCKBITS), .BUSWIDTH(BUSWIDTH)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (pick_d ? d_reqdata : i_reqdata),
    .shift_out ((state == BUS_WDATA) && bus_reqack),
    .shift_in  ((state == BUS_RDATA) && bus_respcyc),
    .beat_in   (bus_resp),
    .beat_out  (beat_out),
    .block     (block),
    .idx       (idx),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt_d      <= 1'b0;
      rr_d       <= 1'b1;
      addr_q     <= '0;
      tag_q      <= '0;
      rd_bus_tag <= '0;
      i_reqack   <= 1'b0;
      d_reqack   <= 1'b0;
      i_respcyc  <= 1'b0;
      d_respcyc  <= 1'b0;
      bus_reqcyc <= 1'b0;
    end else begin
      i_reqack <= 1'b0;
      d_reqack <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            gnt_d      <= pick_d;
            addr_q     <= pick_d ? d_req : i_req;
            tag_q      <= pick_d ? d_reqtag : i_reqtag;
            d_reqack   <= pick_d;
            i_reqack   <= !pick_d;
            rr_d       <= !pick_d;  // the other side wins the next tie
            bus_reqcyc <= 1'b1;
            state      <= BUS_ADDR;
          end
        end
        BUS_ADDR: begin
          if (bus_reqack) begin
            if (is_read) begin
              bus_reqcyc <= 1'b0;
              state      <= BUS_RDATA;
            end else begin
              state      <= BUS_WDATA;
            end
          end
        end
        BUS_WDATA: begin
          if (bus_reqack && last) begin
            bus_reqcyc <= 1'b0;
            d_respcyc  <= gnt_d;
            i_respcyc  <= !gnt_d;
            state      <= CACHE_RESP;
          end
        end
        BUS_RDATA: begin
          if (bus_respcyc) begin
            if (idx == 3'd0)
              rd_bus_tag <= bus_resptag;
            if (last) begin
              d_respcyc <= gnt_d;
              i_respcyc <= !gnt_d;
              state     <= CACHE_RESP;
            end
          end
        end
        CACHE_RESP: begin
          if (gnt_d ? d_respack : i_respack) begin
            d_respcyc <= 1'b0;
            i_respcyc <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data/tag outputs are decoded from registered state so they drop to zero
  // as soon as reset clears the state.
  assign bus_req = (state == BUS_ADDR)  ? {addr_q[63:6], 6'b0} :
                   (state == BUS_WDATA) ? beat_out : 64'd0;
  assign bus_reqtag = (state == BUS_ADDR || state == BUS_WDATA) ? tag_q : '0;

  // Response beats are always accepted; outside BUS_RDATA they are dropped.
  assign bus_respack = bus_respcyc && reset;

  assign in_resp   = (state == CACHE_RESP);
  assign d_resptag = (in_resp && gnt_d)  ? tag_q : '0;
  assign i_resptag = (in_resp && !gnt_d) ? tag_q : '0;
  assign d_resp    = (in_resp && gnt_d  && is_read) ? block : '0;
  assign i_resp    = (in_resp && !gnt_d && is_read) ? block : '0;

  logic unused_sink;
  assign unused_sink = ^{addr_q[5:0], rd_bus_tag, rr_d};

endmodule
